// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD controller.
// The init ROM is only used when LCD_PWRUP_INIT_EN is defined.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC,
    S_PWRUP
  } state_t;

  localparam int BIT_ON      = 31;
  localparam int BIT_CLR_OVF = 11;
  localparam int BIT_QUEUE   = 10;
  localparam int BIT_RS      = 8;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  localparam int INIT_LEN = 6;
  // Entry [0] is sent first.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM =
    {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } entry_t;

  function automatic logic is_long_cmd(entry_t e);
    return !e.rs && (e.data == CMD_CLEAR || e.data == CMD_HOME || e.data == CMD_HOME_ALT);
  endfunction

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Command FIFO for the LCD controller: 9-bit {rs, data} entries, power-of-2 depth,
// same-cycle push and pop legal at any occupancy.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_push,
  input  entry_t i_data,
  input  logic   i_pop,
  output entry_t o_data,
  output logic   o_full,
  output logic   o_empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  // NOTE: storage is not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // When full, a simultaneous push overwrites the head slot only at the edge,
  // after the head has already been read out here.
  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-style LCD controller: queues LSU writes and replays them with RS/EN timing.
// Define LCD_PWRUP_INIT_EN to add a power-up wait and a fixed init sequence after reset.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH       = 4,
  parameter int T_SETUP_CYC      = 3,
  parameter int T_EN_CYC         = 25,
  parameter int T_HOLD_CYC       = 2,
  parameter int T_EXEC_SHORT_CYC = 2000,
  parameter int T_EXEC_LONG_CYC  = 80000,
  parameter int T_PWRUP_CYC      = 750000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_full,
  output logic        o_overflow,
  output logic        o_lcd_on,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic [7:0]  o_lcd_data
);

  localparam int MAX_CYC = max_int(max_int(max_int(T_SETUP_CYC, T_EN_CYC), max_int(T_HOLD_CYC,
                           T_EXEC_SHORT_CYC)), max_int(T_EXEC_LONG_CYC, T_PWRUP_CYC));
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  // Each state lasts exactly N cycles: load N-1 on entry, advance when the count is 0.
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(T_EXEC_SHORT_CYC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG_CYC - 1);

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  entry_t           r_cur, w_head, w_load_entry, w_rom_entry;
  logic             r_overflow, r_lcd_on;
  logic             w_pop, w_push, w_load, w_queue_req, w_drop;
  logic             w_fifo_full, w_fifo_empty, w_init_active;
  logic             w_unused;

`ifdef LCD_PWRUP_INIT_EN
  localparam state_t           RESET_STATE = S_PWRUP;
  localparam logic [CNT_W-1:0] RESET_CNT   = CNT_W'(T_PWRUP_CYC - 1);

  logic       r_init_active;
  logic [2:0] r_rom_idx;
  logic       w_rom_step;

  assign w_init_active = r_init_active;
  assign w_rom_entry   = '{rs: 1'b0, data: INIT_ROM[r_rom_idx]};
  assign w_rom_step    = r_init_active && (r_state == S_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_init_active <= 1'b1;
      r_rom_idx     <= '0;
    end else if (w_rom_step) begin
      r_rom_idx <= r_rom_idx + 1'b1;
      if (r_rom_idx == 3'(INIT_LEN - 1)) r_init_active <= 1'b0;
    end
  end
`else
  localparam state_t           RESET_STATE = S_IDLE;
  localparam logic [CNT_W-1:0] RESET_CNT   = '0;

  assign w_init_active = 1'b0;
  assign w_rom_entry   = '0;
`endif

  lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  ('{rs: i_wdata[BIT_RS], data: i_wdata[7:0]}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_queue_req = i_wr && i_wdata[BIT_QUEUE];
  assign w_push      = w_queue_req && (!w_fifo_full || w_pop);
  assign w_drop      = w_queue_req && w_fifo_full && !w_pop;

  // NOTE: every comb output gets a default before the case, so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_load_entry = w_head;
    unique case (r_state)
      S_IDLE: begin
        if (w_init_active) begin
          w_load       = 1'b1;
          w_load_entry = w_rom_entry;
        end else if (!w_fifo_empty) begin
          w_pop  = 1'b1;
          w_load = 1'b1;
        end
        if (w_load) begin
          w_next_state = S_SETUP;
          w_cnt_next   = LD_SETUP;
        end
      end
      S_SETUP: if (r_cnt == '0) begin w_next_state = S_PULSE; w_cnt_next = LD_EN;   end
      S_PULSE: if (r_cnt == '0) begin w_next_state = S_HOLD;  w_cnt_next = LD_HOLD; end
      S_HOLD: if (r_cnt == '0) begin
        w_next_state = S_EXEC;
        w_cnt_next   = is_long_cmd(r_cur) ? LD_LONG : LD_SHORT;
      end
      S_EXEC:  if (r_cnt == '0) w_next_state = S_IDLE;
      S_PWRUP: if (r_cnt == '0) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= RESET_STATE;
      r_cnt   <= RESET_CNT;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cur      <= '0;
      r_lcd_on   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_load) r_cur <= w_load_entry;
      if (i_wr)   r_lcd_on <= i_wdata[BIT_ON];
      if (w_drop)                           r_overflow <= 1'b1;
      else if (i_wr && i_wdata[BIT_CLR_OVF]) r_overflow <= 1'b0;
    end
  end

  assign w_unused   = &{1'b0, i_wdata[30:12], i_wdata[9]};

  assign o_busy     = (r_state != S_IDLE) || !w_fifo_empty || w_init_active;
  assign o_full     = w_fifo_full;
  assign o_overflow = r_overflow;
  assign o_lcd_on   = r_lcd_on;
  assign o_lcd_rs   = r_cur.rs;
  assign o_lcd_data = r_cur.data;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = (r_state == S_PULSE);

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: a timeline model predicts every output each cycle,
// and directed scenarios pin latency, pulse spacing, overflow and reset behaviour.
module tb_lcd_ctrl;

  localparam int TS = 2, TE = 4, TH = 2, SHORT = 10, LONG = 50, DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_wr = 1'b0;
  logic [31:0] i_wdata = '0;
  logic        o_busy, o_full, o_overflow, o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en;
  logic [7:0]  o_lcd_data;

  lcd_ctrl #(
    .FIFO_DEPTH(DEPTH), .T_SETUP_CYC(TS), .T_EN_CYC(TE), .T_HOLD_CYC(TH),
    .T_EXEC_SHORT_CYC(SHORT), .T_EXEC_LONG_CYC(LONG), .T_PWRUP_CYC(20)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_wr(i_wr), .i_wdata(i_wdata),
    .o_busy(o_busy), .o_full(o_full), .o_overflow(o_overflow), .o_lcd_on(o_lcd_on),
    .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw), .o_lcd_en(o_lcd_en), .o_lcd_data(o_lcd_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model: a popped command occupies the panel for setup+pulse+hold+exec cycles
  // after its pop cycle; the FIFO is a plain queue.
  logic [8:0] q[$];
  logic [8:0] cur = '0;
  logic       m_ovf = 1'b0, m_on = 1'b0;
  int         idle_from = 0;
  int         start = -1000;

  function automatic int dur(logic [8:0] e);
    bit long_cmd = !e[8] && (e[7:0] >= 8'h01) && (e[7:0] <= 8'h03);
    return TS + TE + TH + (long_cmd ? LONG : SHORT);
  endfunction

  task automatic model_step();
    if (rst) begin
      q.delete();
      cur = '0; m_ovf = 1'b0; m_on = 1'b0;
      idle_from = cyc; start = -1000;
    end else begin
      if (cyc >= idle_from && q.size() > 0) begin
        cur = q.pop_front();
        start = cyc;
        idle_from = cyc + 1 + dur(cur);
      end
      if (i_wr) begin
        m_on = i_wdata[31];
        if (i_wdata[10] && q.size() >= DEPTH) m_ovf = 1'b1;
        else begin
          if (i_wdata[11]) m_ovf = 1'b0;
          if (i_wdata[10]) q.push_back({i_wdata[8], i_wdata[7:0]});
        end
      end
      cyc++;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial begin : compare
    int  e;
    bit  active;
    forever begin
      @(negedge clk);
      active = cyc < idle_from;
      e = cyc - start;
      check("busy",     o_busy,     active || q.size() != 0);
      check("full",     o_full,     q.size() == DEPTH);
      check("overflow", o_overflow, m_ovf);
      check("lcd_on",   o_lcd_on,   m_on);
      check("lcd_rs",   o_lcd_rs,   cur[8]);
      check("lcd_data", o_lcd_data, cur[7:0]);
      check("lcd_rw",   o_lcd_rw,   0);
      check("lcd_en",   o_lcd_en,   active && e >= 1 + TS && e < 1 + TS + TE);
    end
  end

  typedef struct { int c; logic rs; logic [7:0] data; } rise_t;
  rise_t rises[$];
  int    falls[$];
  logic  prev_en = 1'b0;

  initial forever begin
    @(negedge clk);
    if (o_lcd_en && !prev_en) rises.push_back('{c: cyc, rs: o_lcd_rs, data: o_lcd_data});
    if (!o_lcd_en && prev_en) falls.push_back(cyc);
    prev_en = o_lcd_en;
  end

  task automatic wr(input logic [31:0] d, output int at);
    @(negedge clk);
    i_wr = 1'b1;
    i_wdata = d;
    at = cyc;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    i_wr = 1'b0;
    i_wdata = '0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", o_busy, 0);
  endtask

  task automatic clear_log();
    #1;
    rises.delete();
    falls.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w0, w2, n;
    logic [7:0] exp_seq[6];

    repeat (3) @(negedge clk);
    check("rst_en", o_lcd_en, 0);
    check("rst_busy", o_busy, 0);
    check("rst_data", o_lcd_data, 0);
    check("rst_ovf", o_overflow, 0);
    rst = 1'b0;
    idle(2);

    // Single character 'A' with RS=1.
    clear_log();
    wr(32'h0000_0541, w);
    idle(1);
    wait_idle(200);
    check("t1_busy_fall", cyc - w, 20);
    #1;
    check("t1_rises", rises.size(), 1);
    if (rises.size() >= 1) begin
      check("t1_latency", rises[0].c - w, 4);
      check("t1_rs", rises[0].rs, 1);
      check("t1_data", rises[0].data, 8'h41);
      if (falls.size() >= 1) check("t1_en_width", falls[0] - rises[0].c, 4);
    end

    // Power bit only: no transfer.
    clear_log();
    wr(32'h8000_0000, w);
    idle(1);
    check("t2_on", o_lcd_on, 1);
    check("t2_busy", o_busy, 0);
    repeat (20) @(negedge clk);
    #1;
    check("t2_no_pulse", rises.size(), 0);

    // Clear (long exec) followed by a character.
    clear_log();
    wr(32'h0000_0401, w);
    wr(32'h0000_0542, w2);
    idle(1);
    wait_idle(300);
    #1;
    check("t3_rises", rises.size(), 2);
    if (rises.size() >= 2) begin
      check("t3_gap", rises[1].c - rises[0].c, 59);
      check("t3_d0", {rises[0].rs, rises[0].data}, 9'h001);
      check("t3_d1", {rises[1].rs, rises[1].data}, 9'h142);
    end

    // Six writes: one popped, four queued, sixth dropped.
    clear_log();
    for (int i = 0; i < 6; i++) wr(32'h0000_0530 + i, w);
    idle(1);
    check("t4_full", o_full, 1);
    check("t4_ovf", o_overflow, 1);
    wait_idle(600);
    #1;
    check("t4_rises", rises.size(), 5);
    for (int i = 0; i < 5 && i < rises.size(); i++)
      check("t4_seq", {rises[i].rs, rises[i].data}, 9'h130 + i);
    check("t4_ovf_sticky", o_overflow, 1);

    // Clear overflow while not full.
    wr(32'h0000_0800, w);
    idle(1);
    check("t5_clr", o_overflow, 0);

    // Drop beats CLR_OVF; then push into a full FIFO on the pop cycle.
    clear_log();
    for (int i = 0; i < 5; i++) begin
      wr(32'h0000_0530 + i, w);
      if (i == 0) w0 = w;
    end
    wr(32'h0000_0D35, w);
    idle(1);
    check("t5_drop_wins", o_overflow, 1);
    check("t5_full", o_full, 1);
    wr(32'h0000_0800, w);
    idle(1);
    check("t5_clr_full", o_overflow, 0);
    while (cyc < w0 + 19) @(negedge clk);
    wr(32'h0000_0536, w);
    idle(1);
    check("t5_pushpop_full", o_full, 1);
    check("t5_pushpop_ovf", o_overflow, 0);
    wait_idle(600);
    #1;
    exp_seq = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h36};
    check("t5_rises", rises.size(), 6);
    for (int i = 0; i < 6 && i < rises.size(); i++)
      check("t5_seq", rises[i].data, exp_seq[i]);

    // Reset in the middle of an EN pulse with commands still queued.
    wr(32'h8000_0541, w);
    wr(32'h8000_0542, w);
    wr(32'h8000_0543, w);
    idle(1);
    n = 0;
    while (!o_lcd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_en_seen", o_lcd_en, 1);
    #1 rst = 1'b1;
    #1;
    check("t6_en_async", o_lcd_en, 0);
    check("t6_busy", o_busy, 0);
    check("t6_on", o_lcd_on, 0);
    check("t6_data", {o_lcd_rs, o_lcd_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    repeat (30) @(negedge clk);
    #1;
    check("t6_fifo_empty", rises.size(), 0);
    check("t6_idle", o_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
HD44780-style character LCD controller; it consumes the LCD register that the LSU writes at 0x7030-0x703F.
- Each accepted write is queued in a small command FIFO.
- Queued commands are replayed to the panel with correct RS/EN setup, pulse, hold and execution timing.
- Busy/full/overflow status is returned to the LSU read mux, so software polls this block instead of bit-banging EN.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
T_SETUP_CYC, 3, cycles RS/DATA stable before EN rises
T_EN_CYC, 25, cycles EN held high
T_HOLD_CYC, 2, cycles RS/DATA held after EN falls
T_EXEC_SHORT_CYC, 2000, wait after a normal command/char (~40us @50MHz)
T_EXEC_LONG_CYC, 80000, wait after clear/home (~1.6ms @50MHz)
T_PWRUP_CYC, 750000, power-up wait, used only with the optional feature (~15ms)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-high reset
i_wr  in  1  one-cycle write strobe: LSU store hit on the LCD address range
i_wdata  in  32  register value; [31]=ON, [11]=CLR_OVF, [10]=QUEUE, [8]=RS, [7:0]=DATA
o_busy  out  1  FSM not IDLE or FIFO not empty
o_full  out  1  FIFO full
o_overflow  out  1  sticky: a queued write was dropped
o_lcd_on  out  1  panel power/backlight
o_lcd_rs  out  1  panel RS
o_lcd_rw  out  1  panel RW, tied 0 (write-only)
o_lcd_en  out  1  panel EN
o_lcd_data  out  8  panel DB[7:0]

Behaviour:
- Reset (async, i_rst=1): FIFO emptied, FSM=IDLE (or PWRUP with the feature), all outputs 0, o_overflow=0. Reset mid-transfer aborts immediately: EN drops to 0 asynchronously.
- Write acceptance, on an i_wr cycle:
  - o_lcd_on <= wdata[31] on the next edge, always, independent of QUEUE.
  - If CLR_OVF=1: o_overflow <= 0.
  - If QUEUE=1 and not full: push {RS, DATA}.
  - If QUEUE=1 and full: entry dropped and o_overflow <= 1. When CLR_OVF=1 and the drop happen in the same write, the drop wins (o_overflow=1).
- FIFO push and pop in the same cycle are both legal at any occupancy.
  - Full + pop + push: accepted, no overflow.
  - Empty + push: the entry is not popped the same cycle (pop only when not empty at the start of the cycle).
- FSM states:
  - IDLE: if FIFO non-empty, pop the head, latch rs/data onto the pins, go to SETUP.
  - SETUP: wait T_SETUP_CYC, go to PULSE.
  - PULSE: EN=1 for exactly T_EN_CYC cycles, go to HOLD.
  - HOLD: EN=0, pins unchanged for T_HOLD_CYC, go to EXEC.
  - EXEC: wait T_EXEC_LONG_CYC if RS=0 and DATA in {0x01,0x02,0x03}, else T_EXEC_SHORT_CYC; then go to IDLE.
- Single down-counter shared across states, loaded on each state entry; a value of 0 means advance next cycle.
- Pins: o_lcd_data/o_lcd_rs hold their last value in IDLE; they change only on pop.
- Latency: i_wr to EN rise with an empty FIFO and IDLE FSM = 2 + T_SETUP_CYC cycles (push, pop/latch, setup).
- Back-to-back commands: the next pop happens in the IDLE cycle after EXEC, so the gap between EN pulses is exact and deterministic.
- o_busy is combinational from the state and FIFO count.

Optional Feature:
Macro LCD_PWRUP_INIT_EN.
- Defined:
  - After reset, the FSM enters PWRUP, waits T_PWRUP_CYC, then replays a fixed ROM (RS=0): 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
  - The ROM is sent through SETUP/PULSE/HOLD/EXEC with the same timing; 0x01 gets the long wait.
  - FIFO pops are blocked until the ROM finishes; user writes still queue during init, and o_busy=1 throughout.
- Undefined: the FSM resets to IDLE, there is no ROM, and software performs init.

Decomposition:
- Package lcd_pkg:
  - state enum (IDLE, SETUP, PULSE, HOLD, EXEC, PWRUP)
  - field bit positions (ON=31, CLR_OVF=11, QUEUE=10, RS=8)
  - command constants (CMD_CLEAR=0x01, CMD_HOME=0x02)
  - init ROM contents
  - 9-bit entry typedef {rs, data}
- One sub-module lcd_cmd_fifo: synchronous FIFO with push/pop/full/empty and same-cycle push+pop. Width 9, depth FIFO_DEPTH, async active-high reset.

Test Plan:
Common bench parameters: T_SETUP=2, T_EN=4, T_HOLD=2, SHORT=10, LONG=50, DEPTH=4.
- Write 0x0000_0541 (QUEUE, RS=1, 'A') -> EN high exactly 4 cycles starting cycle 4 after i_wr; rs=1, data=0x41 stable 2 before/2 after EN; busy falls after EXEC of 10 cycles.
- Write 0x8000_0000 -> o_lcd_on=1 next cycle; no EN pulse; o_busy stays 0.
- Write 0x0000_0401 (clear) then 0x0000_0542 -> second EN rise is exactly 4+2+50+1+2 cycles after the first EN falls... measured rise-to-rise = 4+2+50+1+2=59 cycles.
- Six back-to-back QUEUE writes while IDLE -> 1 popped immediately, 4 queued, the 6th dropped; o_full=1, o_overflow=1; all 5 accepted bytes appear on the pins in order.
- Write with CLR_OVF=1 while overflowed and not full -> o_overflow=0; assert i_rst during PULSE -> o_lcd_en=0 in the same cycle, FIFO empty, all outputs 0.
- With LCD_PWRUP_INIT_EN: release reset -> no EN for T_PWRUP_CYC, then 6 pulses carrying 0x38,0x38,0x38,0x0C,0x01,0x06 with RS=0; a user char written during init appears 7th.
